// File: rtl/mac_job_arbiter_pkg.sv
// Shared types for the MAC job arbiter: job descriptor, FSM state encoding
// and the descriptor field widths.
package mac_job_arbiter_pkg;

   localparam int ITER_W  = 12;  // nb_iter field, value = iterations-1
   localparam int LEN_W   = 16;  // vector length
   localparam int SHIFT_W = 5;   // output shift

   typedef struct packed {
      logic [ITER_W-1:0]  nb_iter;
      logic [LEN_W-1:0]   len;
      logic [SHIFT_W-1:0] shift;
      logic               simple_mul;
   } mac_job_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_RUN   = 3'd2,
      ST_DONE  = 3'd3,
      ST_ABORT = 3'd4
   } mac_arb_state_t;

endpackage

// File: rtl/mac_rr_picker.sv
// Combinational round-robin picker: the first valid requester found when
// searching upward from i_ptr (wrapping modulo N) wins.
module mac_rr_picker #(
   parameter int N  = 2,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  i_valid,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_grant,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);

   // Rotating priority search; the first hit blocks all later candidates.
   always_comb begin
      int j;
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      j       = 0;
      for (int i = 0; i < N; i++) begin
         j = (int'(i_ptr) + i) % N;
         if (!o_any && i_valid[j]) begin
            o_any      = 1'b1;
            o_grant[j] = 1'b1;
            o_idx      = IW'(j);
         end
      end
   end

endmodule

// File: rtl/mac_job_arbiter.sv
// Shares one MAC engine between N_REQ requesters. Round-robin arbitration in
// IDLE, latches the winning descriptor, pulses start, counts iteration
// pulses, runs a watchdog and reports done/error back to the owner.
//
// Handshake: a requester holds req_valid_i with a stable req_job_i; the
// transfer happens on a clock edge where req_valid_i[w] and req_ready_o[w]
// are both high. req_ready_o is one-hot, combinational, and only ever high in
// IDLE. Dropping req_valid_i before that edge forfeits the turn.
module mac_job_arbiter
   import mac_job_arbiter_pkg::*;
#(
   parameter int N_REQ   = 2,
   parameter int TIMEOUT = 1024,  // cycles without an iteration pulse; 0 disables
   parameter int IDX_W   = $clog2(N_REQ)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  clear_i,
   input  logic [N_REQ-1:0]      req_valid_i,
   output logic [N_REQ-1:0]      req_ready_o,
   input  mac_job_t [N_REQ-1:0]  req_job_i,
   output logic                  eng_start_o,
   output mac_job_t              eng_job_o,
   input  logic                  eng_iter_done_i,
   output logic                  eng_abort_o,
   output logic [IDX_W-1:0]      owner_o,
   output logic                  busy_o,
   output logic [N_REQ-1:0]      done_evt_o,
   output logic [N_REQ-1:0]      err_evt_o,
   output mac_arb_state_t        dbg_state_o
);

   localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);

   mac_arb_state_t    r_state;
   mac_arb_state_t    w_state_nxt;
   logic [IDX_W-1:0]  r_ptr;
   logic [IDX_W-1:0]  r_owner;
   mac_job_t          r_job;
   logic [ITER_W-1:0] r_iter_cnt;
   logic [WD_W-1:0]   r_wd_cnt;

   logic [N_REQ-1:0]  w_grant;
   logic [IDX_W-1:0]  w_idx;
   logic              w_any;
   logic              w_arb_en;
   logic              w_last_iter;
   logic              w_wd_expire;
   logic [IDX_W-1:0]  w_ptr_nxt;

   mac_rr_picker #(
      .N  (N_REQ),
      .IW (IDX_W)
   ) u_picker (
      .i_valid (req_valid_i),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   // No handshake may be offered while reset or soft clear is active.
   assign w_arb_en    = !rst_i && !clear_i;
   assign w_last_iter = (r_iter_cnt == r_job.nb_iter);
   assign w_wd_expire = (TIMEOUT != 0) && (r_wd_cnt == WD_LAST);
   assign w_ptr_nxt   = (w_idx == IDX_W'(N_REQ - 1)) ? '0 : w_idx + 1'b1;

   assign eng_job_o   = r_job;
   assign owner_o     = r_owner;
   assign busy_o      = (r_state != ST_IDLE);
   assign dbg_state_o = r_state;

   // State register; soft clear behaves like reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
      end else if (clear_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and Moore-style event outputs; an iteration pulse beats the watchdog.
   always_comb begin
      w_state_nxt = r_state;
      req_ready_o = '0;
      eng_start_o = 1'b0;
      eng_abort_o = 1'b0;
      done_evt_o  = '0;
      err_evt_o   = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_arb_en) begin
               req_ready_o = w_grant;
               if (w_any) w_state_nxt = ST_START;
            end
         end
         ST_START: begin
            eng_start_o = 1'b1;
            w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (eng_iter_done_i) begin
               if (w_last_iter) w_state_nxt = ST_DONE;
            end else if (w_wd_expire) begin
               w_state_nxt = ST_ABORT;
            end
         end
         ST_DONE: begin
            done_evt_o[r_owner] = 1'b1;
            w_state_nxt         = ST_IDLE;
         end
         ST_ABORT: begin
            eng_abort_o        = 1'b1;
            err_evt_o[r_owner] = 1'b1;
            w_state_nxt        = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Descriptor latch, rr pointer, iteration counter and saturating watchdog.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_ptr      <= '0;
         r_owner    <= '0;
         r_job      <= '0;
         r_iter_cnt <= '0;
         r_wd_cnt   <= '0;
      end else if (clear_i) begin
         r_ptr      <= '0;
         r_owner    <= '0;
         r_job      <= '0;
         r_iter_cnt <= '0;
         r_wd_cnt   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_job   <= req_job_i[w_idx];
                  r_owner <= w_idx;
                  r_ptr   <= w_ptr_nxt;
               end
            end
            ST_START: begin
               r_iter_cnt <= '0;
               r_wd_cnt   <= '0;
            end
            ST_RUN: begin
               if (eng_iter_done_i) begin
                  // The final pulse leaves RUN, so the counter never wraps.
                  if (!w_last_iter) r_iter_cnt <= r_iter_cnt + 1'b1;
                  r_wd_cnt <= '0;
               end else if (r_wd_cnt != WD_MAX) begin
                  r_wd_cnt <= r_wd_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mac_job_arbiter.sv
// Directed bench for mac_job_arbiter (N_REQ=2, TIMEOUT=8). The driver pushes
// expected engine/requester events tagged with their expected cycle; a
// negedge monitor pops and compares whenever the DUT emits one.
module tb_mac_job_arbiter;
   import mac_job_arbiter_pkg::*;

   localparam int N_REQ   = 2;
   localparam int TIMEOUT = 8;
   localparam int K_START = 1;
   localparam int K_DONE  = 2;
   localparam int K_ABORT = 3;

   logic                 clk_i = 1'b0;
   logic                 rst_i;
   logic                 clear_i;
   logic [N_REQ-1:0]     req_valid_i;
   logic [N_REQ-1:0]     req_ready_o;
   mac_job_t [N_REQ-1:0] req_job_i;
   logic                 eng_start_o;
   mac_job_t             eng_job_o;
   logic                 eng_iter_done_i;
   logic                 eng_abort_o;
   logic [0:0]           owner_o;
   logic                 busy_o;
   logic [N_REQ-1:0]     done_evt_o;
   logic [N_REQ-1:0]     err_evt_o;
   mac_arb_state_t       dbg_state_o;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   logic [39:0] exp_q[$];

   mac_job_arbiter #(
      .N_REQ   (N_REQ),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .clear_i         (clear_i),
      .req_valid_i     (req_valid_i),
      .req_ready_o     (req_ready_o),
      .req_job_i       (req_job_i),
      .eng_start_o     (eng_start_o),
      .eng_job_o       (eng_job_o),
      .eng_iter_done_i (eng_iter_done_i),
      .eng_abort_o     (eng_abort_o),
      .owner_o         (owner_o),
      .busy_o          (busy_o),
      .done_evt_o      (done_evt_o),
      .err_evt_o       (err_evt_o),
      .dbg_state_o     (dbg_state_o)
   );

   // ---------------- clock / reset ----------------
   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   // ---------------- helpers ----------------
   function automatic logic [39:0] ev(input int c, input int k, input int o, input logic [15:0] len);
      return {16'(c), 4'(k), 4'(o), len};
   endfunction

   function automatic int oh_idx(input logic [N_REQ-1:0] v);
      for (int i = 0; i < N_REQ; i++) if (v[i]) return i;
      return 0;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic got(input string name, input logic [39:0] act);
      logic [39:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL unexpected_%s: got %h expected no event (cycle %0d)", name, act, cyc);
      end else begin
         e = exp_q.pop_front();
         if (act !== e) begin
            failures++;
            $display("FAIL event_%s: got %h expected %h (cycle %0d)", name, act, e, cyc);
         end
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk_i) begin
      if (!rst_i) begin
         if (busy_o) check("ready_outside_idle", 64'(req_ready_o), 64'd0);
         if (eng_start_o) got("start", ev(cyc, K_START, int'(owner_o), eng_job_o.len));
         if (done_evt_o != '0) begin
            check("done_onehot", 64'($onehot(done_evt_o)), 64'd1);
            check("done_owner", 64'(owner_o), 64'(oh_idx(done_evt_o)));
            got("done", ev(cyc, K_DONE, oh_idx(done_evt_o), 16'd0));
         end
         if (err_evt_o != '0 || eng_abort_o) begin
            check("abort_with_err", 64'({eng_abort_o, $onehot(err_evt_o)}), 64'b11);
            got("abort", ev(cyc, K_ABORT, oh_idx(err_evt_o), 16'd0));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   task automatic pulse();
      eng_iter_done_i = 1'b1;
      @(negedge clk_i);
      eng_iter_done_i = 1'b0;
   endtask

   task automatic set_job(input int r, input logic [11:0] nb, input logic [15:0] len);
      req_job_i[r].nb_iter    = nb;
      req_job_i[r].len        = len;
      req_job_i[r].shift      = 5'd3;
      req_job_i[r].simple_mul = 1'b0;
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_busy"}, 64'(busy_o), 64'd0);
      check({tag, "_owner"}, 64'(owner_o), 64'd0);
      check({tag, "_job"}, 64'(eng_job_o), 64'd0);
      check({tag, "_start"}, 64'(eng_start_o), 64'd0);
      check({tag, "_abort"}, 64'(eng_abort_o), 64'd0);
      check({tag, "_evts"}, 64'({done_evt_o, err_evt_o}), 64'd0);
      check({tag, "_state"}, 64'(dbg_state_o), 64'(ST_IDLE));
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      clear_i = 1'b0;
      req_valid_i = '0;
      eng_iter_done_i = 1'b0;
      idle(2);
      rst_i = 1'b0;
      idle(1);
   endtask

   // Called at a negedge in IDLE; returns at the START-cycle negedge.
   task automatic issue(input int r, input logic [11:0] nb, input logic [15:0] len, output int t);
      set_job(r, nb, len);
      req_valid_i[r] = 1'b1;
      #1;
      check("ready_grant", 64'(req_ready_o), 64'(2'b01 << r));
      t = cyc;
      exp_q.push_back(ev(t + 1, K_START, r, len));
      @(negedge clk_i);
      req_valid_i[r] = 1'b0;
   endtask

   // Complete job: nb+1 pulses spaced by gap idle cycles; ends back in IDLE.
   task automatic run_job(input int r, input logic [11:0] nb, input logic [15:0] len, input int gap);
      int t;
      issue(r, nb, len, t);
      idle(1);
      exp_q.push_back(ev(cyc + int'(nb) * (gap + 1) + 1, K_DONE, r, 16'd0));
      for (int i = 0; i <= int'(nb); i++) begin
         pulse();
         if (i < int'(nb)) idle(gap);
      end
      idle(1);
   endtask

   int exp_grant[4] = '{0, 1, 0, 1};

   // ---------------- main sequence ----------------
   initial begin
      int t;
      req_job_i = '0;
      do_reset();
      check_idle_zero("reset");
      check("reset_ready", 64'(req_ready_o), 64'd0);

      // T1: single job, nb_iter=3, len=64, back-to-back pulses
      issue(0, 12'd3, 16'd64, t);
      idle(1);
      exp_q.push_back(ev(t + 6, K_DONE, 0, 16'd0));
      repeat (4) pulse();
      check("t1_busy_in_done", 64'(busy_o), 64'd1);
      idle(1);
      check("t1_busy_low", 64'(busy_o), 64'd0);

      // T2: both held valid from a fresh reset, single-iteration jobs
      do_reset();
      set_job(0, 12'd0, 16'h0010);
      set_job(1, 12'd0, 16'h0020);
      req_valid_i = 2'b11;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("t2_grant", 64'(req_ready_o), 64'(2'b01 << exp_grant[k]));
         exp_q.push_back(ev(cyc + 1, K_START, exp_grant[k], (exp_grant[k] == 0) ? 16'h0010 : 16'h0020));
         exp_q.push_back(ev(cyc + 3, K_DONE, exp_grant[k], 16'd0));
         @(negedge clk_i);
         @(negedge clk_i);
         eng_iter_done_i = 1'b1;
         @(negedge clk_i);
         eng_iter_done_i = 1'b0;
         @(negedge clk_i);
      end
      req_valid_i = '0;
      idle(1);

      // T3: watchdog abort, no iteration pulses
      issue(1, 12'd5, 16'h0033, t);
      exp_q.push_back(ev(t + 10, K_ABORT, 1, 16'd0));
      idle(12);
      check("t3_idle_after_abort", 64'(busy_o), 64'd0);

      // T4: pulse on the exact cycle the watchdog would fire, twice
      issue(0, 12'd1, 16'h0044, t);
      exp_q.push_back(ev(t + 18, K_DONE, 0, 16'd0));
      idle(8);
      pulse();
      idle(7);
      pulse();
      idle(1);
      check("t4_idle", 64'(busy_o), 64'd0);

      // T6: pulses in IDLE, at handshake, in START and after DONE are ignored
      pulse();
      eng_iter_done_i = 1'b1;
      issue(1, 12'd1, 16'h0066, t);
      @(negedge clk_i);
      eng_iter_done_i = 1'b0;
      exp_q.push_back(ev(t + 4, K_DONE, 1, 16'd0));
      pulse();
      pulse();
      pulse();
      pulse();
      idle(2);
      check("t6_idle", 64'(busy_o), 64'd0);

      // T5a: soft clear mid-RUN; pointer returns to 0
      run_job(1, 12'd0, 16'h0070, 0);
      issue(0, 12'd3, 16'h0055, t);
      idle(1);
      pulse();
      clear_i = 1'b1;
      @(negedge clk_i);
      clear_i = 1'b0;
      check_idle_zero("clear");
      set_job(0, 12'd0, 16'h0011);
      set_job(1, 12'd0, 16'h0022);
      req_valid_i = 2'b11;
      #1;
      check("clear_ptr_grant", 64'(req_ready_o), 64'b01);
      exp_q.push_back(ev(cyc + 1, K_START, 0, 16'h0011));
      @(negedge clk_i);
      req_valid_i = '0;
      idle(1);
      exp_q.push_back(ev(cyc + 1, K_DONE, 0, 16'd0));
      pulse();
      idle(1);

      // T5b: asynchronous reset mid-RUN with owner 1
      issue(1, 12'd3, 16'h0077, t);
      idle(1);
      pulse();
      #2;
      rst_i = 1'b1;
      #1;
      check_idle_zero("async_rst");
      @(negedge clk_i);
      rst_i = 1'b0;
      run_job(0, 12'd2, 16'h0099, 1);

      idle(3);
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Bound on total run time.
   initial begin
      #100000;
      failures++;
      $display("FAIL global_timeout: got running expected finished (cycle %0d)", cyc);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
